// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller: FSM states,
// opcodes, datapath select encodings and ALU control codes.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } mc_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OP_I, OP_LOAD: sel = IMM_I;
            OP_STORE:      sel = IMM_S;
            OP_BRANCH:     sel = IMM_B;
            OP_JAL:        sel = IMM_J;
            default:       sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's coarse alu_op intent plus the instruction's
// funct fields into the ALU control code.
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       op_b5,
    output logic [2:0] alu_ctrl
);

    // Only register-register ops (op[5]=1) with funct7[5] set select subtract.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (funct7_b5 && op_b5) begin
                            alu_ctrl = ALU_SUB;
                        end else begin
                            alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I core with a sticky trap flag.
// Define MC_MEM_WAIT_EN to honour mem_ready; otherwise memory is zero-wait.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       instr_done,
    output logic       trap
);

    mc_state_t  state_r;
    mc_state_t  next_state_s;
    logic       trap_r;
    logic       ready_s;
    logic [1:0] alu_op_s;
    logic       mem_req_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic       instr_done_s;

`ifdef MC_MEM_WAIT_EN
    assign ready_s = mem_ready;
`else
    logic unused_mem_ready_s;
    assign ready_s            = 1'b1;
    assign unused_mem_ready_s = mem_ready;
`endif

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            trap_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == ILLEGAL) begin
                trap_r <= 1'b1;
            end
        end
    end

    // Next-state and Moore datapath controls; stalled memory states simply hold.
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        adr_src      = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        result_src   = RES_ALUOUT;
        alu_op_s     = ALUOP_ADD;
        instr_done_s = 1'b0;
        case (state_r)
            FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write_s = ready_s;
                pc_write_s = ready_s;
                if (ready_s) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state_s = MEMADR;
                    OP_R:              next_state_s = EXECUTER;
                    OP_I:              next_state_s = EXECUTEI;
                    OP_BRANCH:         next_state_s = BEQ;
                    OP_JAL:            next_state_s = JAL;
                    default:           next_state_s = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                if (op[5]) begin
                    next_state_s = MEMWRITE;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src   = 1'b1;
                if (ready_s) begin
                    next_state_s = MEMWB;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMWB: begin
                result_src   = RES_DATA;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                mem_req_s    = 1'b1;
                mem_write_s  = 1'b1;
                adr_src      = 1'b1;
                instr_done_s = ready_s;
                if (ready_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWRITE;
                end
            end
            EXECUTER: begin
                alu_src_a    = SRC_A_RS1;
                alu_op_s     = ALUOP_FUNCT;
                next_state_s = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_IMM;
                alu_op_s     = ALUOP_FUNCT;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            BEQ: begin
                alu_src_a    = SRC_A_RS1;
                alu_op_s     = ALUOP_SUB;
                pc_write_s   = zero ^ funct3[0];
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            JAL: begin
                alu_src_a    = SRC_A_OLDPC;
                alu_src_b    = SRC_B_FOUR;
                pc_write_s   = 1'b1;
                next_state_s = ALUWB;
            end
            ILLEGAL: next_state_s = ILLEGAL;
            default: next_state_s = ILLEGAL;
        endcase
    end

    aludec u_aludec (
        .alu_op    (alu_op_s),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .op_b5     (op[5]),
        .alu_ctrl  (alu_ctrl)
    );

    // Enables are gated by reset asynchronously so nothing fires while rst_n is low.
    assign mem_req    = mem_req_s    & rst_n;
    assign mem_write  = mem_write_s  & rst_n;
    assign ir_write   = ir_write_s   & rst_n;
    assign pc_write   = pc_write_s   & rst_n;
    assign reg_write  = reg_write_s  & rst_n;
    assign instr_done = instr_done_s & rst_n;
    assign imm_src    = imm_src_of(op);
    assign trap       = trap_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; expected control
// vectors are hand-derived per FSM state.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_ctrl;
    logic       instr_done, trap;
    logic [16:0] obs;
    int n_cmp;
    int n_fail;

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write}, a, b, result_src, alu_ctrl, instr_done
    localparam logic [16:0] E_RESET       = {6'b000000, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [16:0] E_FETCH       = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [16:0] E_FETCH_STALL = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [16:0] E_DECODE      = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] E_MEMADR      = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] E_MEMREAD     = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] E_MEMWB       = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 1'b1};
    localparam logic [16:0] E_MEMWRITE    = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
    localparam logic [16:0] E_MEMWR_STALL = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] E_EXEC_SUB    = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [16:0] E_EXEC_ADDI   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] E_ALUWB       = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
    localparam logic [16:0] E_BEQ_TAKEN   = {6'b000010, 2'b10, 2'b00, 2'b00, 3'b001, 1'b1};
    localparam logic [16:0] E_BEQ_NOT     = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b001, 1'b1};
    localparam logic [16:0] E_JAL         = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] E_ZERO        = 17'b0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_b5(funct7_b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_ctrl(alu_ctrl), .instr_done(instr_done), .trap(trap)
    );

    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_ctrl, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7_b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        #3;
        n_cmp++;
        if ({trap, obs} !== {1'b0, E_RESET}) begin
            n_fail++; $display("FAIL reset_async: got %h want %h", {trap, obs}, {1'b0, E_RESET});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({trap, obs} !== {1'b0, E_RESET}) begin
            n_fail++; $display("FAIL reset_held: got %h want %h", {trap, obs}, {1'b0, E_RESET});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [16:0] exp_v [5];
        exp_v = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
        op = 7'b0000011; funct3 = 3'b010; funct7_b5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL lw cycle %0d: got %h want %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (imm_src !== 3'b000) begin
            n_fail++; $display("FAIL lw imm_src: got %b want 000", imm_src);
        end
    endtask

    task automatic test_sw();
`ifdef MC_MEM_WAIT_EN
        localparam int N = 7;
        logic        rdy [N];
        logic [16:0] exp_v [N];
        rdy   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_v = '{E_FETCH_STALL, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR_STALL, E_MEMWR_STALL, E_MEMWRITE};
`else
        localparam int N = 4;
        logic        rdy [N];
        logic [16:0] exp_v [N];
        rdy   = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp_v = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE};
`endif
        op = 7'b0100011; funct3 = 3'b010; funct7_b5 = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL sw cycle %0d: got %h want %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        n_cmp++;
        if (imm_src !== 3'b001) begin
            n_fail++; $display("FAIL sw imm_src: got %b want 001", imm_src);
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp_v [6];
        exp_v = '{E_FETCH, E_DECODE, E_BEQ_TAKEN, E_FETCH, E_DECODE, E_BEQ_NOT};
        op = 7'b1100011; funct7_b5 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            funct3 = (i < 3) ? 3'b000 : 3'b001;
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL branch cycle %0d: got %h want %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (imm_src !== 3'b010) begin
            n_fail++; $display("FAIL branch imm_src: got %b want 010", imm_src);
        end
        zero = 1'b0;
    endtask

    task automatic test_alu();
        logic [16:0] exp_v [8];
        logic [2:0]  sw_f3 [6];
        logic        sw_f7 [6];
        logic [2:0]  sw_ctl [6];
        exp_v  = '{E_FETCH, E_DECODE, E_EXEC_SUB, E_ALUWB, E_FETCH, E_DECODE, E_EXEC_ADDI, E_ALUWB};
        sw_f3  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
        sw_f7  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sw_ctl = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = (i < 4) ? 7'b0110011 : 7'b0010011;
            funct3 = 3'b000; funct7_b5 = 1'b1;
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL alu cycle %0d: got %h want %h", i, obs, exp_v[i]);
            end
            if (i == 2) begin
                for (int j = 0; j < 6; j++) begin
                    funct3 = sw_f3[j]; funct7_b5 = sw_f7[j];
                    #1;
                    n_cmp++;
                    if (alu_ctrl !== sw_ctl[j]) begin
                        n_fail++; $display("FAIL alu_decode %0d: got %b want %b", j, alu_ctrl, sw_ctl[j]);
                    end
                end
                funct3 = 3'b000; funct7_b5 = 1'b1;
            end
            @(posedge clk); #1;
        end
        funct7_b5 = 1'b0;
    endtask

    task automatic test_jal();
        logic [16:0] exp_v [4];
        exp_v = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB};
        op = 7'b1101111; funct3 = 3'b000; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL jal cycle %0d: got %h want %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (imm_src !== 3'b011) begin
            n_fail++; $display("FAIL jal imm_src: got %b want 011", imm_src);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp_v [4];
        exp_v = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD};
        op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL rstmid cycle %0d: got %h want %h", i, obs, exp_v[i]);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_RESET) begin
            n_fail++; $display("FAIL rstmid gated: got %h want %h", obs, E_RESET);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== E_FETCH) begin
            n_fail++; $display("FAIL rstmid refetch: got %h want %h", obs, E_FETCH);
        end
    endtask

    task automatic test_illegal();
        logic [17:0] exp_t;
        op = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      exp_t = {1'b0, E_FETCH};
            else if (i == 1) exp_t = {1'b0, E_DECODE};
            else             exp_t = {1'b1, E_ZERO};
            #1;
            n_cmp++;
            if ({trap, obs} !== exp_t) begin
                n_fail++; $display("FAIL illegal cycle %0d: got %h want %h", i, {trap, obs}, exp_t);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({trap, obs} !== {1'b0, E_RESET}) begin
            n_fail++; $display("FAIL illegal reset: got %h want %h", {trap, obs}, {1'b0, E_RESET});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; op = 7'b0110011;
        #1;
        n_cmp++;
        if ({trap, obs} !== {1'b0, E_FETCH}) begin
            n_fail++; $display("FAIL illegal refetch: got %h want %h", {trap, obs}, {1'b0, E_FETCH});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_alu();
        test_jal();
        test_reset_mid();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
